// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller.
package mem_ctrl_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  // Request latched at grant; the RAM address register doubles as the running address.
  typedef struct packed {
    owner_t      owner;
    logic [2:0]  n;
    logic [31:0] wdata;
  } xfer_t;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      MEM_LEN_BYTE: return 3'd1;
      MEM_LEN_HALF: return 3'd2;
      MEM_LEN_WORD: return 3'd4;
      default:      return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, MEM-stage and RAM-side signals of the shared byte-wide RAM port.
interface mem_ctrl_if #(
  parameter int RAM_ADDR_W = 17
);

  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_flush;
  logic [31:0]           if_data;
  logic                  if_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;

  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output ram_din,
    input  if_data, if_done,
    input  mem_rdata, mem_done,
    input  ram_a, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  ram_din,
    output if_data, if_done,
    output mem_rdata, mem_done,
    output ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM between fetch and MEM (MEM first); N-byte read done in cycle N+2, write in N+1.
// Requesters hold req until their done pulse; new requests are only sampled in IDLE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  mc_state_t             state_q;
  xfer_t                 xfer_q;
  logic [2:0]            cnt_q;
  logic [31:0]           buf_q;
  logic [31:0]           buf_next;
  logic [1:0]            cap_idx;
  logic [1:0]            nxt_idx;

  logic [RAM_ADDR_W-1:0] ram_a_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;
  logic [31:0]           if_data_q;
  logic                  if_done_q;
  logic [31:0]           mem_rdata_q;
  logic                  mem_done_q;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:RAM_ADDR_W], bus.mem_addr[31:RAM_ADDR_W]};

  // In RD, cnt_q = k means byte k-1 is on ram_din this cycle.
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign nxt_idx = cnt_q[1:0] + 2'd1;

  always_comb begin
    buf_next = buf_q;
    if (state_q == MC_RD && cnt_q != 3'd0) begin
      buf_next[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      xfer_q      <= '{owner: OWNER_IF, n: 3'd0, wdata: ZERO_WORD};
      cnt_q       <= 3'd0;
      buf_q       <= ZERO_WORD;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_data_q   <= ZERO_WORD;
      if_done_q   <= 1'b0;
      mem_rdata_q <= ZERO_WORD;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        MC_IDLE: begin
          cnt_q <= 3'd0;
          buf_q <= ZERO_WORD;
          if (bus.mem_req) begin
            xfer_q  <= '{owner: OWNER_MEM, n: len_to_n(bus.mem_len), wdata: bus.mem_wdata};
            ram_a_q <= bus.mem_addr[RAM_ADDR_W-1:0];
            if (bus.mem_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus.mem_wdata[7:0];
              state_q    <= MC_WR;
            end else begin
              state_q <= MC_RD;
            end
          end else if (bus.if_req && !bus.if_flush) begin
            xfer_q  <= '{owner: OWNER_IF, n: 3'd4, wdata: ZERO_WORD};
            ram_a_q <= bus.if_addr[RAM_ADDR_W-1:0];
            state_q <= MC_RD;
          end
        end

        MC_RD: begin
          // A redirect kills the fetch; the byte still in flight is never captured.
          if (xfer_q.owner == OWNER_IF && bus.if_flush) begin
            state_q <= MC_IDLE;
          end else begin
            buf_q <= buf_next;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q + 3'd1 < xfer_q.n) begin
              ram_a_q <= ram_a_q + RAM_ADDR_W'(1);
            end
            if (cnt_q == xfer_q.n) begin
              state_q <= MC_DONE;
              if (xfer_q.owner == OWNER_IF) begin
                if_data_q <= byte_swap(buf_next);
                if_done_q <= 1'b1;
              end else begin
                mem_rdata_q <= buf_next;
                mem_done_q  <= 1'b1;
              end
            end
          end
        end

        MC_WR: begin
          if (cnt_q + 3'd1 == xfer_q.n) begin
            state_q    <= MC_DONE;
            ram_wr_q   <= 1'b0;
            mem_done_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_a_q    <= ram_a_q + RAM_ADDR_W'(1);
            ram_dout_q <= xfer_q.wdata[{nxt_idx, 3'b000} +: 8];
          end
        end

        MC_DONE: begin
          state_q <= MC_IDLE;
        end

        default: begin
          state_q <= MC_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_data   = if_data_q;
  // A flush landing on the done cycle still cancels the fetch.
  assign bus.if_done   = if_done_q & ~bus.if_flush;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single transfers plus arbitration, flush and reset sequences.
module tb_mem_ctrl;

  localparam int AW = 17;
  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.RAM_ADDR_W(AW)) bus ();
  mem_ctrl #(.RAM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model: registered read, one cycle after the address.
  logic [7:0]    ram [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_dat;
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
    if (pl_we) ram[pl_addr] <= pl_dat;
    bus.ram_din <= ram[bus.ram_a];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      pl_we   = 1'b1;
      pl_addr = AW'(addr + 32'(i));
      pl_dat  = word[8*i +: 8];
      cyc();
    end
    pl_we = 1'b0;
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ram[AW'(addr + 32'(i))];
    return w;
  endfunction

  typedef struct {
    int          kind;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_req(input vec_t v, output int lat, output logic [31:0] data,
                         output logic [31:0] first_a, output int wr_cnt,
                         output logic extra_done, output logic got_if);
    lat = -1; data = '0; first_a = '0; wr_cnt = 0; extra_done = 1'b0; got_if = 1'b0;
    if (v.kind == K_FETCH) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = (v.kind == K_STORE);
      bus.mem_len   = v.len;
      bus.mem_addr  = v.addr;
      bus.mem_wdata = v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 1) first_a = 32'(bus.ram_a);
      if (bus.ram_wr) wr_cnt++;
      if (bus.if_done || bus.mem_done) begin
        lat    = c;
        got_if = bus.if_done;
        data   = (v.kind == K_FETCH) ? bus.if_data : bus.mem_rdata;
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        cyc();
        extra_done = bus.if_done | bus.mem_done;
        break;
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
  endtask

  initial begin
    int          lat, wr_cnt, n, hit;
    logic [31:0] data, first_a, w;
    logic        extra_done, got_if, seen_wr, seen_done;

    vecs[0] = '{K_FETCH, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_0513, 32'h1305_0000, 6};
    vecs[1] = '{K_LOAD,  2'd2, 32'h0000_0010, 32'h0,         32'h4433_2211, 32'h4433_2211, 6};
    vecs[2] = '{K_LOAD,  2'd0, 32'h0000_0021, 32'h0,         32'hEEDD_CCA5, 32'h0000_00A5, 3};
    vecs[3] = '{K_LOAD,  2'd1, 32'h0001_FFFF, 32'h0,         32'h9988_7F80, 32'h0000_7F80, 4};
    vecs[4] = '{K_LOAD,  2'd3, 32'h0000_0030, 32'h0,         32'h0403_0201, 32'h0403_0201, 6};
    vecs[5] = '{K_FETCH, 2'd0, 32'h0000_0103, 32'h0,         32'hDDCC_BBAA, 32'hAABB_CCDD, 6};
    vecs[6] = '{K_STORE, 2'd0, 32'h0000_0050, 32'hFFFF_FFC3, 32'h4433_2211, 32'h4433_22C3, 2};
    vecs[7] = '{K_STORE, 2'd1, 32'h0000_0060, 32'h1234_ABCD, 32'h8877_6655, 32'h8877_ABCD, 3};
    vecs[8] = '{K_STORE, 2'd2, 32'h0001_FFFE, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 5};

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_dat = '0;

    // Reset held two cycles, then idle with no requests.
    cyc();
    cyc();
    rst = 1'b0;
    seen_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.ram_wr) seen_wr = 1'b1;
    end
    check("reset if_data",   bus.if_data, 32'h0);
    check("reset if_done",   32'(bus.if_done), 32'h0);
    check("reset mem_rdata", bus.mem_rdata, 32'h0);
    check("reset mem_done",  32'(bus.mem_done), 32'h0);
    check("reset ram_a",     32'(bus.ram_a), 32'h0);
    check("reset ram_dout",  32'(bus.ram_dout), 32'h0);
    check("reset ram_wr",    32'(seen_wr), 32'h0);

    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].addr, vecs[i].init);
      run_req(vecs[i], lat, data, first_a, wr_cnt, extra_done, got_if);
      n = (vecs[i].len == 2'd0) ? 1 : (vecs[i].len == 2'd1) ? 2 : 4;
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d first ram_a", i), first_a, 32'(AW'(vecs[i].addr)));
      check($sformatf("v%0d write strobes", i), 32'(wr_cnt), (vecs[i].kind == K_STORE) ? 32'(n) : 32'h0);
      check($sformatf("v%0d done owner", i), 32'(got_if), 32'(vecs[i].kind == K_FETCH));
      check($sformatf("v%0d done width", i), 32'(extra_done), 32'h0);
      if (vecs[i].kind == K_STORE) check($sformatf("v%0d ram word", i), ram_word(vecs[i].addr), vecs[i].exp);
      else                         check($sformatf("v%0d data", i), data, vecs[i].exp);
    end

    // MEM store and fetch requested together: MEM first, IF granted after MEM's DONE.
    preload(32'h104, 32'h6745_2301);
    preload(32'h200, 32'h0);
    w = 32'hDEAD_BEEF;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h200; bus.mem_wdata = w;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("prio c%0d ram_wr", k), 32'(bus.ram_wr), 32'h1);
      check($sformatf("prio c%0d ram_a", k), 32'(bus.ram_a), 32'h200 + 32'(k - 1));
      check($sformatf("prio c%0d ram_dout", k), 32'(bus.ram_dout), 32'(w[8*(k-1) +: 8]));
    end
    cyc();
    check("prio c5 mem_done", 32'(bus.mem_done), 32'h1);
    check("prio c5 if_done", 32'(bus.if_done), 32'h0);
    bus.mem_req = 1'b0;
    hit = -1;
    for (int c = 6; c <= 30; c++) begin
      cyc();
      if (bus.if_done) begin
        hit = c;
        data = bus.if_data;
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    check("prio if_done cycle", 32'(hit), 32'd12);
    check("prio if_data", data, 32'h0123_4567);
    check("prio stored word", ram_word(32'h200), w);

    // Fetch aborted by flush in cycle 3, then a new fetch at 0x40.
    preload(32'h40, 32'h0C0B_0A09);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    cyc();
    cyc();
    cyc();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    cyc();
    check("flush c4 if_done", 32'(bus.if_done), 32'h0);
    bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h40;
    hit = -1;
    for (int c = 5; c <= 30; c++) begin
      cyc();
      if (bus.if_done) begin
        hit = c;
        data = bus.if_data;
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    check("flush refetch cycle", 32'(hit), 32'd10);
    check("flush refetch data", data, 32'h090A_0B0C);
    cyc();

    // Flush coinciding with the fetch's done cycle suppresses if_done.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    seen_done = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (bus.if_done) seen_done = 1'b1;
    end
    cyc();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    #1;
    if (bus.if_done) seen_done = 1'b1;
    check("flush at done if_done", 32'(seen_done), 32'h0);
    cyc();
    bus.if_flush = 1'b0;
    cyc();

    // Reset asserted in cycle 2 of a 4 B store.
    preload(32'h300, 32'h0);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h300; bus.mem_wdata = 32'h1122_3344;
    cyc();
    cyc();
    rst = 1'b1; bus.mem_req = 1'b0;
    seen_wr = 1'b0; seen_done = 1'b0;
    cyc();
    rst = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      if (bus.ram_wr) seen_wr = 1'b1;
      if (bus.mem_done) seen_done = 1'b1;
      cyc();
    end
    check("rst mid-store ram_wr", 32'(seen_wr), 32'h0);
    check("rst mid-store mem_done", 32'(seen_done), 32'h0);
    check("rst mid-store partial word", ram_word(32'h300), 32'h0000_3344);
    vecs[0] = '{K_STORE, 2'd2, 32'h0000_0300, 32'hA1B2_C3D4, 32'h0, 32'hA1B2_C3D4, 5};
    run_req(vecs[0], lat, data, first_a, wr_cnt, extra_done, got_if);
    check("restart latency", 32'(lat), 32'd5);
    check("restart first ram_a", first_a, 32'h300);
    check("restart strobes", 32'(wr_cnt), 32'd4);
    check("restart word", ram_word(32'h300), 32'hA1B2_C3D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
